fpu_wb: RTL and testbench
=========================

Name: fpu_wb

Overview:
Writeback/result-capture stage directly downstream of the FPU, and owner of its issue-side stall.
- Tracks which FPU pipeline slots hold valid operations, with their tags.
- Captures Result/flags when a tracked op leaves the pipeline and buffers them in a small FIFO.
- Presents results to the consumer via valid/ready and keeps sticky exception flags.
- Drives the FPU Stall input so the FPU pipeline never produces a result the FIFO cannot hold.

Parameters:
C_OP, 32, result width
TAG_W, 5, tag width (destination register id)
LATENCY, 2, un-stalled cycles from accepted issue to result on Result_DI (FPU input reg + core)
DEPTH, 4, result FIFO entries; power of two, >= 2

Ports:
Clk_CI  in  1  clock
Rst_RI  in  1  synchronous active-high reset
Valid_SI  in  1  upstream issue request (same cycle operands go to FPU)
Tag_DI  in  TAG_W  tag of issued op
Ready_SO  out  1  issue accepted when Valid_SI & Ready_SO; equals ~Stall_SO
Stall_SO  out  1  to FPU Stall_SI; freezes FPU pipeline and tag pipe
Result_DI  in  C_OP  FPU Result_DO
OF_SI, UF_SI, Zero_SI, IX_SI, IV_SI, Inf_SI  in  1 each  FPU flags
Valid_SO  out  1  FIFO head valid
Ready_SI  in  1  consumer pop
Result_DO  out  C_OP  head result
Tag_DO  out  TAG_W  head tag
Flags_DO  out  6  head flags {Inf,IV,IX,Zero,UF,OF}
Sticky_DO  out  4  accumulated {IV,IX,UF,OF}
Clear_SI  in  1  clear sticky flags

Behaviour:
- Tag pipe: LATENCY stages of {valid, tag}.
  - Stage 0 loads {Valid_SI & Ready_SO, Tag_DI}.
  - Shifts every cycle Stall_SO=0; holds entirely when Stall_SO=1.
- Capture: when Stall_SO=0 and last stage is valid, write {Result_DI, flags, tag} to FIFO at the clock edge.
  - Invalid last stage: Result_DI is ignored.
- Stall_SO = (count_q + inflight_q) >= DEPTH.
  - count_q is FIFO occupancy; inflight_q is the number of valid tag-pipe stages.
  - Computed from registered state only. A same-cycle pop does not lower it (deliberately conservative, no Ready_SI->Stall_SO path).
  - Invariant: count_q + inflight_q <= DEPTH, so the FIFO never overflows.
- FIFO: registered, no bypass.
  - Captured entry is visible on outputs the cycle after the capture edge.
  - End-to-end latency, issue to Valid_SO, is LATENCY+1 cycles with no stalls.
  - Pop on Valid_SO & Ready_SI; outputs are stable while Valid_SO=1 and not popped.
  - Ready_SI while empty is ignored.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Read/write pointers of log2(DEPTH) bits wrap naturally.
- Throughput: 1 op/cycle sustained when DEPTH >= LATENCY+2 and Ready_SI held 1.
- Sticky_DO:
  - OR-accumulates {IV,IX,UF,OF} of each captured entry.
  - Clear_SI alone zeroes it.
  - Clear_SI together with a capture: the result equals the captured entry's flags (capture wins over clear).
- Reset (any time, including mid-operation):
  - Tag-pipe valids = 0, pointers/count = 0, Sticky_DO = 0.
  - In-flight FPU results are discarded.
  - Cycle after reset: Valid_SO=0, Stall_SO=0, Ready_SO=1.
  - Result_DO/Tag_DO/Flags_DO are don't-care while Valid_SO=0; the FIFO storage is not reset.
- No state machine beyond the FIFO/pipe counters; ordering is strictly in issue order.

Test Plan:
1. Reset, then single issue Tag=3 at cycle 0, FPU returns 0x3F800000 at cycle 2 -> Valid_SO=1 at cycle 3 with Result_DO=0x3F800000, Tag_DO=3; pop with Ready_SI=1 -> Valid_SO=0 at cycle 4.
2. Back-to-back issue of tags 0..7, Ready_SI=1, DEPTH=4, LATENCY=2 -> Stall_SO never asserted; Tag_DO emits 0..7 in order on cycles 3..10.
3. Ready_SI=0, issue continuously -> Stall_SO rises on the cycle count+inflight reaches 4; exactly 4 results are buffered (2 captured + 2 held in pipe, frozen); no loss. Raise Ready_SI -> all drain in order.
4. Results with flags IV=1 then OF=1 -> Sticky_DO=4'b1001. Clear_SI on a cycle capturing an IX=1 result -> Sticky_DO=4'b0100.
5. Assert Rst_RI with 2 ops in flight and 2 in FIFO -> next cycle Valid_SO=0, Stall_SO=0, Sticky_DO=0; stale Result_DI is never captured.
6. FIFO full and Ready_SI=1 with a tracked op in the last stage -> Stall_SO stays 1 this cycle (conservative); pop completes; next cycle Stall_SO=0 and the capture occurs.

Source files
------------

// File: rtl/fpu_wb_if.sv
// Bundle of the issue-side, FPU-return and consumer-side signals of the
// FPU writeback stage. The slave side is the writeback block itself; the
// master side is whatever surrounds it (issue logic, FPU, consumer).
interface fpu_wb_if #(
    parameter int C_OP  = 32,
    parameter int TAG_W = 5
);
    // Issue side
    logic             Valid_SI;
    logic [TAG_W-1:0] Tag_DI;
    logic             Ready_SO;
    logic             Stall_SO;
    // FPU return
    logic [C_OP-1:0]  Result_DI;
    logic             OF_SI;
    logic             UF_SI;
    logic             Zero_SI;
    logic             IX_SI;
    logic             IV_SI;
    logic             Inf_SI;
    // Consumer side
    logic             Valid_SO;
    logic             Ready_SI;
    logic [C_OP-1:0]  Result_DO;
    logic [TAG_W-1:0] Tag_DO;
    logic [5:0]       Flags_DO;
    logic [3:0]       Sticky_DO;
    logic             Clear_SI;

    modport slave (
        input  Valid_SI, Tag_DI, Result_DI,
        input  OF_SI, UF_SI, Zero_SI, IX_SI, IV_SI, Inf_SI,
        input  Ready_SI, Clear_SI,
        output Ready_SO, Stall_SO, Valid_SO, Result_DO, Tag_DO, Flags_DO, Sticky_DO
    );

    modport master (
        output Valid_SI, Tag_DI, Result_DI,
        output OF_SI, UF_SI, Zero_SI, IX_SI, IV_SI, Inf_SI,
        output Ready_SI, Clear_SI,
        input  Ready_SO, Stall_SO, Valid_SO, Result_DO, Tag_DO, Flags_DO, Sticky_DO
    );
endinterface

// File: rtl/fpu_wb.sv
// FPU writeback stage: tracks in-flight FPU ops with a tag pipe, captures
// their results into a small FIFO, keeps sticky exception flags and stalls
// the FPU whenever the FIFO could not absorb everything already in flight.
module fpu_wb #(
    parameter int C_OP    = 32,
    parameter int TAG_W   = 5,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic     Clk_CI,
    input  logic     Rst_RI,
    fpu_wb_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + LATENCY + 1);
    localparam int ENT_W = C_OP + 6 + TAG_W;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [TAG_W-1:0]   tag_q [LATENCY];
    logic [TAG_W-1:0]   tag_d [LATENCY];
    cnt_t               inflight_q, inflight_d;
    cnt_t               count_q, count_d;
    ptr_t               wptr_q, wptr_d;
    ptr_t               rptr_q, rptr_d;
    logic [3:0]         sticky_q, sticky_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [ENT_W-1:0]   mem_d [DEPTH];

    logic       stall;
    logic       issue;
    logic       push;
    logic       pop;
    logic [5:0] flags_in;
    logic [3:0] exc_in;

    // Stall, handshakes and all next-state values. Stall looks only at
    // registered occupancy so a same-cycle pop never feeds back into it.
    always_comb begin
        stall    = (count_q + inflight_q) >= cnt_t'(DEPTH);
        issue    = bus.Valid_SI & ~stall;
        push     = ~stall & vld_q[LATENCY-1];
        pop      = bus.Ready_SI & (count_q != '0);
        flags_in = {bus.Inf_SI, bus.IV_SI, bus.IX_SI, bus.Zero_SI, bus.UF_SI, bus.OF_SI};
        exc_in   = {bus.IV_SI, bus.IX_SI, bus.UF_SI, bus.OF_SI};

        vld_d      = vld_q;
        tag_d      = tag_q;
        inflight_d = inflight_q;
        if (!stall) begin
            vld_d[0] = issue;
            tag_d[0] = bus.Tag_DI;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                tag_d[i] = tag_q[i-1];
            end
            inflight_d = inflight_q + cnt_t'(issue) - cnt_t'(push);
        end

        count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        wptr_d  = wptr_q + ptr_t'(push);
        rptr_d  = rptr_q + ptr_t'(pop);

        mem_d = mem_q;
        if (push) begin
            mem_d[wptr_q] = {bus.Result_DI, flags_in, tag_q[LATENCY-1]};
        end

        // A capture in the same cycle as a clear wins over the clear.
        sticky_d = sticky_q;
        if (push) begin
            sticky_d = bus.Clear_SI ? exc_in : (sticky_q | exc_in);
        end else if (bus.Clear_SI) begin
            sticky_d = '0;
        end
    end

    // Control state: reset discards everything tracked, including in-flight ops.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            vld_q      <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            sticky_q   <= '0;
        end else begin
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            sticky_q   <= sticky_d;
        end
    end

    // Tag and result storage; contents only matter where a valid bit says so.
    always_ff @(posedge Clk_CI) begin
        tag_q <= tag_d;
        mem_q <= mem_d;
    end

    assign bus.Stall_SO  = stall;
    assign bus.Ready_SO  = ~stall;
    assign bus.Valid_SO  = (count_q != '0);
    assign bus.Sticky_DO = sticky_q;
    assign {bus.Result_DO, bus.Flags_DO, bus.Tag_DO} = mem_q[rptr_q];
endmodule

// File: tb/tb_fpu_wb.sv
// Bench for fpu_wb: a behavioural FPU pipeline drives Result_DI, accepted
// issues go into a scoreboard queue in issue order, and a negedge monitor
// checks handshakes, stall, sticky flags and popped entries against it.
module tb_fpu_wb;
    localparam int C_OP    = 32;
    localparam int TAG_W   = 5;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;

    typedef struct {
        logic [C_OP-1:0]  res;
        logic [TAG_W-1:0] tag;
        logic [5:0]       flg;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_wb_if #(.C_OP(C_OP), .TAG_W(TAG_W)) bus ();

    fpu_wb #(.C_OP(C_OP), .TAG_W(TAG_W), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .Clk_CI (clk),
        .Rst_RI (rst),
        .bus    (bus)
    );

    // Behavioural FPU: operands travel LATENCY stages, frozen by Stall_SO.
    logic [LATENCY-1:0] fv;
    logic [C_OP-1:0]    fr [LATENCY];
    logic [5:0]         ff [LATENCY];
    logic [C_OP-1:0]    nxt_res;
    logic [5:0]         nxt_flg;

    assign bus.Result_DI = fr[LATENCY-1];
    assign bus.OF_SI     = ff[LATENCY-1][0];
    assign bus.UF_SI     = ff[LATENCY-1][1];
    assign bus.Zero_SI   = ff[LATENCY-1][2];
    assign bus.IX_SI     = ff[LATENCY-1][3];
    assign bus.IV_SI     = ff[LATENCY-1][4];
    assign bus.Inf_SI    = ff[LATENCY-1][5];

    exp_t       sb [$];
    int         cap_cnt;
    logic [3:0] sticky_e;
    int         vectors;
    int         miscompares;
    bit         chk_en;

    initial begin
        fv = '0;
        for (int i = 0; i < LATENCY; i++) begin
            fr[i] = $urandom;
            ff[i] = 6'($urandom);
        end
        cap_cnt  = 0;
        sticky_e = '0;
        vectors  = 0;
        miscompares = 0;
        chk_en   = 1'b0;
    end

    // Reference model: what is accepted, captured and accumulated at each edge.
    always @(posedge clk) begin
        logic acc, cap, pop;
        logic [3:0] f4;
        if (rst) begin
            sb.delete();
            cap_cnt  = 0;
            sticky_e = '0;
            fv <= '0;
        end else begin
            acc = bus.Valid_SI && bus.Ready_SO;
            cap = !bus.Stall_SO && fv[LATENCY-1];
            pop = (cap_cnt > 0) && bus.Ready_SI;
            f4  = {ff[LATENCY-1][4], ff[LATENCY-1][3], ff[LATENCY-1][1], ff[LATENCY-1][0]};
            if (cap) sticky_e = bus.Clear_SI ? f4 : (sticky_e | f4);
            else if (bus.Clear_SI) sticky_e = '0;
            cap_cnt = cap_cnt + int'(cap) - int'(pop);
            if (acc) sb.push_back('{res: nxt_res, tag: bus.Tag_DI, flg: nxt_flg});
            if (!bus.Stall_SO) begin
                for (int i = 1; i < LATENCY; i++) begin
                    fv[i] <= fv[i-1];
                    fr[i] <= fr[i-1];
                    ff[i] <= ff[i-1];
                end
                fv[0] <= acc;
                fr[0] <= acc ? nxt_res : C_OP'($urandom);
                ff[0] <= acc ? nxt_flg : 6'($urandom);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: compare outputs mid-cycle, pop the scoreboard on a handshake.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            check("ready_vs_stall", 32'(bus.Ready_SO), 32'(!bus.Stall_SO));
            check("stall", 32'(bus.Stall_SO), 32'(sb.size() >= DEPTH));
            check("valid", 32'(bus.Valid_SO), 32'(cap_cnt > 0));
            check("sticky", 32'(bus.Sticky_DO), 32'(sticky_e));
            if (bus.Valid_SO === 1'b1 && bus.Ready_SI === 1'b1) begin
                if (sb.size() == 0) begin
                    check("pop_nonempty_sb", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("result", bus.Result_DO, e.res);
                    check("tag", 32'(bus.Tag_DO), 32'(e.tag));
                    check("flags", 32'(bus.Flags_DO), 32'(e.flg));
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input logic [TAG_W-1:0] t,
                         input logic [C_OP-1:0] r, input logic [5:0] f);
        bus.Valid_SI = v;
        bus.Tag_DI   = t;
        nxt_res      = r;
        nxt_flg      = f;
    endtask

    initial begin
        rst          = 1'b1;
        bus.Ready_SI = 1'b0;
        bus.Clear_SI = 1'b0;
        drive(1'b0, '0, '0, '0);
        cyc(2);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Single op, Tag=3, result 1.0f, consumer ready.
        bus.Ready_SI = 1'b1;
        drive(1'b1, 5'd3, 32'h3F800000, 6'h00);
        cyc();
        drive(1'b0, '0, '0, '0);
        cyc(6);

        // Back-to-back tags 0..7 with the consumer always ready.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, TAG_W'(i), $urandom, 6'($urandom));
            cyc();
        end
        drive(1'b0, '0, '0, '0);
        cyc(6);

        // Consumer blocked while issuing continuously, then drain.
        bus.Ready_SI = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, TAG_W'(i + 8), $urandom, 6'($urandom));
            cyc();
        end
        drive(1'b0, '0, '0, '0);
        bus.Ready_SI = 1'b1;
        cyc(10);

        // Sticky accumulation: IV then OF, then clear on an IX capture.
        drive(1'b1, 5'd20, $urandom, 6'b010000);
        cyc();
        drive(1'b1, 5'd21, $urandom, 6'b000001);
        cyc();
        drive(1'b0, '0, '0, '0);
        cyc(4);
        drive(1'b1, 5'd22, $urandom, 6'b001000);
        cyc();
        drive(1'b0, '0, '0, '0);
        cyc();
        bus.Clear_SI = 1'b1;
        cyc();
        bus.Clear_SI = 1'b0;
        cyc(3);
        bus.Clear_SI = 1'b1;
        cyc();
        bus.Clear_SI = 1'b0;

        // Reset with two ops buffered and two in flight.
        bus.Ready_SI = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, TAG_W'(i + 24), $urandom, 6'h1B);
            cyc();
        end
        drive(1'b0, '0, '0, '0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.Ready_SI = 1'b1;
        cyc(6);

        // Full occupancy with an op waiting in the last stage, then release.
        bus.Ready_SI = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, TAG_W'(i), $urandom, 6'($urandom));
            cyc();
        end
        drive(1'b0, '0, '0, '0);
        bus.Ready_SI = 1'b1;
        cyc(8);

        // Random traffic with occasional clear and reset.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) != 0, TAG_W'($urandom), $urandom, 6'($urandom));
            bus.Ready_SI = ($urandom % 3) != 0;
            bus.Clear_SI = ($urandom % 8) == 0;
            rst          = ($urandom % 97) == 0;
            cyc();
        end
        drive(1'b0, '0, '0, '0);
        rst          = 1'b0;
        bus.Clear_SI = 1'b0;
        bus.Ready_SI = 1'b1;

        // Drain with a bounded wait.
        for (int i = 0; i < 50 && (sb.size() != 0 || cap_cnt != 0); i++) cyc();
        if (sb.size() != 0 || cap_cnt != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d outstanding, expected 0", sb.size());
        end
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
